clic_hart_irq_sink: RTL

// Hart-side end of the CLIC interrupt handshake (irq_valid/irq_ready/id/level/shv/priv).
// - Filters each CLIC request against hart state: privilege, global enable, current level, threshold.
// - Accepts eligible requests, holds them as a trap request to the core until acknowledged.
// - Computes the SHV vector-table address.
// - Maintains mil/sil and previous-level (mpil/spil) state across trap entry and mret/sret.
//

---
 rtl/clic_hart_pkg.sv | 50 +++++
 rtl/clic_hart_irq_sink_elig.sv | 40 ++++
 rtl/clic_hart_irq_sink.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clic_hart_pkg.sv
// Shared types and helpers for the hart-side CLIC interrupt sink.
// Privilege encodings, handshake FSM states and the latched trap record.
package clic_hart_pkg;

   localparam int N_SOURCE = 256;
   localparam int SRC_W    = $clog2(N_SOURCE);
   localparam int XLEN     = 32;
   localparam int LVL_W    = 8;

   localparam logic [1:0] PRIV_U    = 2'd0;
   localparam logic [1:0] PRIV_S    = 2'd1;
   localparam logic [1:0] PRIV_RSVD = 2'd2;
   localparam logic [1:0] PRIV_M    = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

   typedef struct packed {
      logic [SRC_W-1:0] id;
      logic [LVL_W-1:0] level;
      logic [1:0]       priv;
      logic             shv;
      logic [XLEN-1:0]  vec_addr;
   } trap_t;

   typedef struct packed {
      logic [LVL_W-1:0] mil;
      logic [LVL_W-1:0] sil;
      logic [LVL_W-1:0] mpil;
      logic [LVL_W-1:0] spil;
   } lvl_t;

   function automatic logic [LVL_W-1:0] lvl_max(input logic [LVL_W-1:0] a,
                                                input logic [LVL_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Table base is forced to 64-byte alignment; the sum wraps silently at 2^XLEN.
   function automatic logic [XLEN-1:0] vec_addr(input logic [XLEN-1:0]  tvt,
                                                input logic [SRC_W-1:0] id);
      logic [XLEN-1:0] base;
      logic [XLEN-1:0] offs;
      base = {tvt[XLEN-1:6], 6'b0};
      offs = {{(XLEN-SRC_W){1'b0}}, id} * XLEN'(XLEN/8);
      return base + offs;
   endfunction

endpackage

// File: rtl/clic_hart_irq_sink_elig.sv
// Combinational CLIC eligibility check: level vs. current level/threshold and privilege gating.
// Zero latency; no state, so no backpressure of its own.
module clic_irq_elig
   import clic_hart_pkg::*;
(
   input  logic [LVL_W-1:0] irq_level_i,
   input  logic [1:0]       irq_priv_i,
   input  logic [1:0]       cur_priv_i,
   input  logic             mie_i,
   input  logic             sie_i,
   input  logic [LVL_W-1:0] mil_i,
   input  logic [LVL_W-1:0] sil_i,
   input  logic [LVL_W-1:0] mintthresh_i,
   input  logic [LVL_W-1:0] sintthresh_i,
   output logic             elig_o
);

   logic m_ok;
   logic s_ok;

   assign m_ok = (irq_level_i > lvl_max(mil_i, mintthresh_i))
               & ((cur_priv_i != PRIV_M) | mie_i);

   // S interrupts are masked outright while running in M mode.
   assign s_ok = (cur_priv_i != PRIV_M)
               & (irq_level_i > lvl_max(sil_i, sintthresh_i))
               & ((cur_priv_i == PRIV_U) | sie_i);

   always_comb begin
      elig_o = 1'b0;
      if (irq_level_i != '0) begin
         unique case (irq_priv_i)
            PRIV_M:  elig_o = m_ok;
            PRIV_S:  elig_o = s_ok;
            default: elig_o = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/clic_hart_irq_sink.sv
// Hart-side CLIC sink: filters and accepts one request, holds it as a trap until the core acks.
// trap_req_o rises one cycle after the transfer; irq_ready_o stays low while a trap is pending.
module clic_hart_irq_sink
   import clic_hart_pkg::*;
#(
   parameter int N_SOURCE = clic_hart_pkg::N_SOURCE,
   parameter int SRC_W    = $clog2(N_SOURCE),
   parameter int XLEN     = clic_hart_pkg::XLEN
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             irq_valid_i,
   output logic             irq_ready_o,
   input  logic [SRC_W-1:0] irq_id_i,
   input  logic [7:0]       irq_level_i,
   input  logic             irq_shv_i,
   input  logic [1:0]       irq_priv_i,
   input  logic [1:0]       cur_priv_i,
   input  logic             mie_i,
   input  logic             sie_i,
   input  logic [7:0]       mintthresh_i,
   input  logic [7:0]       sintthresh_i,
   input  logic [XLEN-1:0]  mtvt_i,
   input  logic [XLEN-1:0]  stvt_i,
   output logic             trap_req_o,
   input  logic             trap_ack_i,
   output logic [SRC_W-1:0] trap_id_o,
   output logic [7:0]       trap_level_o,
   output logic [1:0]       trap_priv_o,
   output logic             trap_shv_o,
   output logic [XLEN-1:0]  trap_vec_addr_o,
   input  logic             mret_i,
   input  logic             sret_i,
   output logic [7:0]       mil_o,
   output logic [7:0]       sil_o,
   output logic [7:0]       mpil_o,
   output logic [7:0]       spil_o
);

   state_e state_q, state_d;
   trap_t  trap_q,  trap_d;
   lvl_t   lvl_q,   lvl_d;
   logic   elig;
   logic   xfer;
   logic   ack;

   clic_irq_elig u_elig (
      .irq_level_i  (irq_level_i),
      .irq_priv_i   (irq_priv_i),
      .cur_priv_i   (cur_priv_i),
      .mie_i        (mie_i),
      .sie_i        (sie_i),
      .mil_i        (lvl_q.mil),
      .sil_i        (lvl_q.sil),
      .mintthresh_i (mintthresh_i),
      .sintthresh_i (sintthresh_i),
      .elig_o       (elig)
   );

   always_comb begin
      state_d     = state_q;
      trap_d      = trap_q;
      irq_ready_o = 1'b0;
      trap_req_o  = 1'b0;
      xfer        = 1'b0;
      ack         = 1'b0;
      unique case (state_q)
         IDLE: begin
            irq_ready_o = irq_valid_i & elig;
            xfer        = irq_ready_o;
            if (xfer) begin
               trap_d.id       = irq_id_i;
               trap_d.level    = irq_level_i;
               trap_d.priv     = irq_priv_i;
               trap_d.shv      = irq_shv_i;
               trap_d.vec_addr = irq_shv_i
                               ? vec_addr((irq_priv_i == PRIV_M) ? mtvt_i : stvt_i, irq_id_i)
                               : '0;
               state_d         = PEND;
            end
         end
         PEND: begin
            trap_req_o = 1'b1;
            ack        = trap_ack_i;
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Returns apply first so a same-cycle ack for the same privilege overrides them.
   always_comb begin
      lvl_d = lvl_q;
      if (mret_i) begin
         lvl_d.mil = lvl_q.mpil;
      end
      if (sret_i) begin
         lvl_d.sil = lvl_q.spil;
      end
      if (ack) begin
         if (trap_q.priv == PRIV_M) begin
            lvl_d.mpil = lvl_q.mil;
            lvl_d.mil  = trap_q.level;
         end else if (trap_q.priv == PRIV_S) begin
            lvl_d.spil = lvl_q.sil;
            lvl_d.sil  = trap_q.level;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         trap_q  <= '0;
         lvl_q   <= '0;
      end else begin
         state_q <= state_d;
         trap_q  <= trap_d;
         lvl_q   <= lvl_d;
      end
   end

   assign trap_id_o       = trap_q.id;
   assign trap_level_o    = trap_q.level;
   assign trap_priv_o     = trap_q.priv;
   assign trap_shv_o      = trap_q.shv;
   assign trap_vec_addr_o = trap_q.vec_addr;
   assign mil_o           = lvl_q.mil;
   assign sil_o           = lvl_q.sil;
   assign mpil_o          = lvl_q.mpil;
   assign spil_o          = lvl_q.spil;

endmodule
